// File: rtl/decode_pkg.sv
// Types and constants shared by the decode and execute stages.
package decode_pkg;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7_5;
        logic [1:0]  ALUOp;
        logic        ALUSrc;
        logic [2:0]  ImmSel;
        logic        Branch;
        logic        RegWrite;
        logic        MemRead;
        logic        MemWrite;
        logic        MemToReg;
    } id_ex_t;

endpackage

// File: rtl/execute_pkg.sv
// EX/MEM packet, ALU operation encoding and the small helpers used by the execute stage.
package execute_pkg;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        RegWrite;
        logic        MemRead;
        logic        MemWrite;
        logic        MemToReg;
    } ex_mem_t;

    // Only R-type may turn funct3=000 into SUB; I-type honours funct7_5 for SRAI alone.
    function automatic alu_op_e alu_decode(input logic [1:0] aluop, input logic [2:0] funct3,
                                           input logic funct7_5);
        alu_op_e op;
        op = ALU_ADD;
        if (aluop == ALUOP_R || aluop == ALUOP_I) begin
            case (funct3)
                3'b000:  op = (aluop == ALUOP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b001:  op = ALU_SLL;
                3'b010:  op = ALU_SLT;
                3'b011:  op = ALU_SLTU;
                3'b100:  op = ALU_XOR;
                3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
                3'b110:  op = ALU_OR;
                default: op = ALU_AND;
            endcase
        end
        return op;
    endfunction

    // EX/MEM is the newer producer, so it is checked first; loads there never forward.
    function automatic logic [31:0] fwd_select(input logic [4:0] rs, input logic [31:0] raw,
                                               input logic em_regwrite, input logic em_memtoreg,
                                               input logic [4:0] em_rd, input logic [31:0] em_result,
                                               input logic wb_we, input logic [4:0] wb_addr,
                                               input logic [31:0] wb_data);
        if (em_regwrite && !em_memtoreg && em_rd != 5'd0 && em_rd == rs)
            return em_result;
        if (wb_we && wb_addr != 5'd0 && wb_addr == rs)
            return wb_data;
        return raw;
    endfunction

endpackage

// File: rtl/execute_alu.sv
// RV32I integer ALU.
// Latency: combinational. Backpressure: none.
module execute_alu
    import execute_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    always_comb begin
        y = a + b;
        case (op)
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'd0, a < b};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = a + b;
        endcase
    end

endmodule

// File: rtl/execute.sv
// EX stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
// Latency: 1 cycle id_ex -> ex_mem; take_branch/branch_target are combinational.
// Backpressure: we=0 freezes EX/MEM and masks take_branch so a frozen branch cannot flush itself.
module execute
    import decode_pkg::*;
    import execute_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit FWD_ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            we,
    input  id_ex_t          id_ex,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      wb_addr,
    input  logic            wb_we,
    output logic            take_branch,
    output logic [XLEN-1:0] branch_target,
    output ex_mem_t         ex_mem
);

    logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_b, alu_y, jump_base, target, result;
    alu_op_e         alu_op;
    logic            is_jal, is_jalr, is_br, br_cond;
    ex_mem_t         ex_mem_d;

    assign fwd_rs1 = FWD_ENABLE ? fwd_select(id_ex.rs1, id_ex.rs1_data, ex_mem.RegWrite,
                                             ex_mem.MemToReg, ex_mem.rd, ex_mem.alu_result,
                                             wb_we, wb_addr, wb_data)
                                : id_ex.rs1_data;
    assign fwd_rs2 = FWD_ENABLE ? fwd_select(id_ex.rs2, id_ex.rs2_data, ex_mem.RegWrite,
                                             ex_mem.MemToReg, ex_mem.rd, ex_mem.alu_result,
                                             wb_we, wb_addr, wb_data)
                                : id_ex.rs2_data;

    assign op_b   = id_ex.ALUSrc ? id_ex.imm : fwd_rs2;
    assign alu_op = alu_decode(id_ex.ALUOp, id_ex.funct3, id_ex.funct7_5);

    execute_alu u_alu (
        .op (alu_op),
        .a  (fwd_rs1),
        .b  (op_b),
        .y  (alu_y)
    );

    always_comb begin
        br_cond = 1'b0;
        case (id_ex.funct3)
            3'b000:  br_cond = (fwd_rs1 == fwd_rs2);
            3'b001:  br_cond = (fwd_rs1 != fwd_rs2);
            3'b100:  br_cond = ($signed(fwd_rs1) <  $signed(fwd_rs2));
            3'b101:  br_cond = ($signed(fwd_rs1) >= $signed(fwd_rs2));
            3'b110:  br_cond = (fwd_rs1 <  fwd_rs2);
            3'b111:  br_cond = (fwd_rs1 >= fwd_rs2);
            default: br_cond = 1'b0;
        endcase
    end

    assign is_jal      = (id_ex.ImmSel == IMM_J);
    assign is_jalr     = id_ex.Branch && (id_ex.ImmSel == IMM_I);
    assign is_br       = id_ex.Branch && (id_ex.ImmSel == IMM_B);
    assign take_branch = we && (is_jal || is_jalr || (is_br && br_cond));

    // pc_plus4 - 4 recovers the instruction's own PC; JALR clears bit 0 of its target.
    assign jump_base     = is_jalr ? fwd_rs1 : (id_ex.pc_plus4 - XLEN'(4));
    assign target        = (jump_base + id_ex.imm) & ~XLEN'(is_jalr);
    assign branch_target = take_branch ? target : '0;

    always_comb begin
        result = alu_y;
        if (id_ex.ImmSel == IMM_U)
            result = id_ex.imm;
        else if (is_jal || is_jalr)
            result = id_ex.pc_plus4;
    end

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.alu_result = result;
        ex_mem_d.store_data = fwd_rs2;
        ex_mem_d.pc_plus4   = id_ex.pc_plus4;
        ex_mem_d.rd         = id_ex.rd;
        ex_mem_d.funct3     = id_ex.funct3;
        ex_mem_d.RegWrite   = id_ex.RegWrite;
        ex_mem_d.MemRead    = id_ex.MemRead;
        ex_mem_d.MemWrite   = id_ex.MemWrite;
        ex_mem_d.MemToReg   = id_ex.MemToReg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ex_mem <= '0;
        else if (we)
            ex_mem <= ex_mem_d;
    end

endmodule

// File: tb/tb_execute.sv
// Bench for the EX stage: directed cases plus random instruction streams against a
// mnemonic-level model of RV32I execute semantics with forwarding.
module tb_execute;
    import decode_pkg::*;
    import execute_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0;
    id_ex_t      id_ex = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  wb_addr = '0;
    logic        wb_we = 1'b0;
    logic        take_branch;
    logic [31:0] branch_target;
    ex_mem_t     ex_mem;

    execute #(.XLEN(32), .FWD_ENABLE(1'b1)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .we            (we),
        .id_ex         (id_ex),
        .wb_data       (wb_data),
        .wb_addr       (wb_addr),
        .wb_we         (wb_we),
        .take_branch   (take_branch),
        .branch_target (branch_target),
        .ex_mem        (ex_mem)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef enum int {
        K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
        K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
        K_LW, K_SW, K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU, K_BNONE,
        K_JAL, K_JALR, K_LUI, K_NOP
    } kind_e;

    typedef struct {
        kind_e       k;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm, pc4;
    } instr_t;

    ex_mem_t mdl_q  = '0;
    bit      mdl_br = 1'b0;

    function automatic instr_t mk(input kind_e k, input int rs1, input int rs2, input int rd,
                                  input logic [31:0] d1, input logic [31:0] d2,
                                  input logic [31:0] imm, input logic [31:0] pc4);
        instr_t i;
        i.k = k; i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.rd = 5'(rd);
        i.d1 = d1; i.d2 = d2; i.imm = imm; i.pc4 = pc4;
        return i;
    endfunction

    function automatic logic [2:0] f3(input instr_t i);
        case (i.k)
            K_SLL, K_SLLI, K_BNE:                  return 3'd1;
            K_SLT, K_SLTI, K_LW, K_SW:             return 3'd2;
            K_BNONE:                               return i.rd[0] ? 3'd3 : 3'd2;
            K_SLTU, K_SLTIU:                       return 3'd3;
            K_XOR, K_XORI, K_BLT:                  return 3'd4;
            K_SRL, K_SRA, K_SRLI, K_SRAI, K_BGE:   return 3'd5;
            K_OR, K_ORI, K_BLTU:                   return 3'd6;
            K_AND, K_ANDI, K_BGEU:                 return 3'd7;
            default:                               return 3'd0;
        endcase
    endfunction

    function automatic id_ex_t encode(input instr_t i);
        id_ex_t p;
        p = '0;
        if (i.k == K_NOP) return p;
        p.rs1 = i.rs1; p.rs2 = i.rs2; p.rd = i.rd;
        p.rs1_data = i.d1; p.rs2_data = i.d2; p.imm = i.imm; p.pc_plus4 = i.pc4;
        p.funct3 = f3(i);
        case (i.k)
            K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND: begin
                p.ALUOp = 2'b10; p.RegWrite = 1'b1;
                p.funct7_5 = (i.k == K_SUB || i.k == K_SRA);
            end
            K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI: begin
                p.ALUOp = 2'b11; p.ALUSrc = 1'b1; p.RegWrite = 1'b1; p.funct7_5 = i.imm[10];
            end
            K_LW:   begin p.ALUSrc = 1'b1; p.RegWrite = 1'b1; p.MemRead = 1'b1; p.MemToReg = 1'b1; end
            K_SW:   begin p.ALUSrc = 1'b1; p.MemWrite = 1'b1; p.ImmSel = IMM_S; end
            K_JAL:  begin p.ImmSel = IMM_J; p.RegWrite = 1'b1; end
            K_JALR: begin p.Branch = 1'b1; p.ALUSrc = 1'b1; p.RegWrite = 1'b1; p.ImmSel = IMM_I; end
            K_LUI:  begin p.ImmSel = IMM_U; p.ALUSrc = 1'b1; p.RegWrite = 1'b1; end
            default: begin p.ALUOp = 2'b01; p.Branch = 1'b1; p.ImmSel = IMM_B; end
        endcase
        return p;
    endfunction

    // Newest value of a register as seen by the instruction now in EX.
    function automatic logic [31:0] mfwd(input logic [4:0] rs, input logic [31:0] raw);
        if (mdl_q.RegWrite && !mdl_q.MemToReg && mdl_q.rd != 0 && mdl_q.rd == rs) return mdl_q.alu_result;
        if (wb_we && wb_addr != 0 && wb_addr == rs) return wb_data;
        return raw;
    endfunction

    function automatic void model(input instr_t i, output ex_mem_t nx, output bit br,
                                  output bit tk, output logic [31:0] tg);
        logic [31:0] a, b, r;
        a = mfwd(i.rs1, i.d1);
        b = mfwd(i.rs2, i.d2);
        r = '0; br = 1'b0; tk = 1'b0;
        case (i.k)
            K_ADD:   r = a + b;
            K_SUB:   r = a - b;
            K_SLL:   r = a << b[4:0];
            K_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            K_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
            K_XOR:   r = a ^ b;
            K_SRL:   r = a >> b[4:0];
            K_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
            K_OR:    r = a | b;
            K_AND:   r = a & b;
            K_ADDI, K_LW, K_SW: r = a + i.imm;
            K_SLTI:  r = ($signed(a) < $signed(i.imm)) ? 32'd1 : 32'd0;
            K_SLTIU: r = (a < i.imm) ? 32'd1 : 32'd0;
            K_XORI:  r = a ^ i.imm;
            K_ORI:   r = a | i.imm;
            K_ANDI:  r = a & i.imm;
            K_SLLI:  r = a << i.imm[4:0];
            K_SRLI:  r = a >> i.imm[4:0];
            K_SRAI:  r = $unsigned($signed(a) >>> i.imm[4:0]);
            K_BEQ:   begin br = 1'b1; tk = (a == b); end
            K_BNE:   begin br = 1'b1; tk = (a != b); end
            K_BLT:   begin br = 1'b1; tk = ($signed(a) < $signed(b)); end
            K_BGE:   begin br = 1'b1; tk = ($signed(a) >= $signed(b)); end
            K_BLTU:  begin br = 1'b1; tk = (a < b); end
            K_BGEU:  begin br = 1'b1; tk = (a >= b); end
            K_BNONE: br = 1'b1;
            K_JAL, K_JALR: begin r = i.pc4; tk = 1'b1; end
            K_LUI:   r = i.imm;
            default: r = a + b;
        endcase
        tg = (i.k == K_JALR) ? ((a + i.imm) & 32'hFFFF_FFFE) : (i.pc4 - 32'd4 + i.imm);
        nx = '0;
        nx.alu_result = br ? 32'd0 : r;
        nx.store_data = b;
        nx.pc_plus4   = i.pc4;
        nx.rd         = i.rd;
        nx.funct3     = f3(i);
        nx.RegWrite   = !br && !(i.k inside {K_SW, K_NOP});
        nx.MemRead    = (i.k == K_LW);
        nx.MemWrite   = (i.k == K_SW);
        nx.MemToReg   = (i.k == K_LW);
    endfunction

    function automatic ex_mem_t masked(input ex_mem_t e, input bit br);
        if (br) e.alu_result = '0;
        return e;
    endfunction

    task automatic step(input instr_t i, input logic w, input string tag,
                        output logic tk_o, output logic [31:0] tg_o);
        ex_mem_t     nx;
        bit          br, tk;
        logic [31:0] tg;
        id_ex = encode(i);
        we    = w;
        #1;
        model(i, nx, br, tk, tg);
        tk_o = take_branch;
        tg_o = branch_target;
        check({tag, ".take"}, take_branch, w & tk);
        if (w && tk) check({tag, ".target"}, branch_target, tg);
        if (w) begin
            mdl_q  = nx;
            mdl_br = br;
        end
        @(posedge clk);
        #1;
        check({tag, ".ex_mem"}, masked(ex_mem, mdl_br), masked(mdl_q, mdl_br));
    endtask

    initial begin
        logic        tk;
        logic [31:0] tg;
        instr_t      ri;

        #1;
        check("reset.ex_mem", ex_mem, '0);
        check("reset.take", take_branch, 1'b0);
        #12 reset_n = 1'b1;
        @(posedge clk);
        #1;

        step(mk(K_ADD, 1, 2, 3, 5, 7, 0, 32'h100), 1'b1, "add", tk, tg);
        check("add.result", ex_mem.alu_result, 32'd12);
        check("add.rd", ex_mem.rd, 5'd3);
        check("add.regwrite", ex_mem.RegWrite, 1'b1);
        step(mk(K_SUB, 5, 6, 4, 0, 1, 0, 32'h104), 1'b1, "sub", tk, tg);
        check("sub.result", ex_mem.alu_result, 32'hFFFF_FFFF);

        step(mk(K_ADDI, 0, 0, 1, 0, 0, 10, 32'h108), 1'b1, "addi", tk, tg);
        step(mk(K_ADD, 1, 1, 2, 0, 0, 0, 32'h10C), 1'b1, "fwd_em", tk, tg);
        check("fwd_em.result", ex_mem.alu_result, 32'd20);
        step(mk(K_ADDI, 0, 0, 1, 0, 0, 10, 32'h110), 1'b1, "addi2", tk, tg);
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd99;
        step(mk(K_ADD, 1, 1, 2, 0, 0, 0, 32'h114), 1'b1, "fwd_prio", tk, tg);
        check("fwd_prio.result", ex_mem.alu_result, 32'd20);
        wb_we = 1'b0;

        step(mk(K_BLT, 10, 11, 0, 32'hFFFF_FFFF, 1, 32'h20, 32'h104), 1'b1, "blt", tk, tg);
        check("blt.take", tk, 1'b1);
        check("blt.target", tg, 32'h120);
        step(mk(K_BLTU, 10, 11, 0, 32'hFFFF_FFFF, 1, 32'h20, 32'h104), 1'b1, "bltu", tk, tg);
        check("bltu.take", tk, 1'b0);

        step(mk(K_JALR, 7, 0, 5, 32'h1001, 0, 4, 32'h204), 1'b1, "jalr", tk, tg);
        check("jalr.take", tk, 1'b1);
        check("jalr.target", tg, 32'h1004);
        check("jalr.result", ex_mem.alu_result, 32'h204);
        step(mk(K_ADD, 10, 11, 9, 3, 4, 0, 32'h208), 1'b1, "add9", tk, tg);
        step(mk(K_JALR, 7, 0, 5, 32'h1001, 0, 4, 32'h204), 1'b0, "jalr_stall", tk, tg);
        check("jalr_stall.take", tk, 1'b0);
        check("jalr_stall.held", ex_mem.alu_result, 32'd7);
        step(mk(K_JALR, 7, 0, 5, 32'h1001, 0, 4, 32'h204), 1'b1, "jalr_go", tk, tg);
        check("jalr_go.take", tk, 1'b1);
        check("jalr_go.result", ex_mem.alu_result, 32'h204);

        step(mk(K_SRAI, 12, 0, 13, 32'h8000_0000, 0, 32'h404, 32'h210), 1'b1, "srai", tk, tg);
        check("srai.result", ex_mem.alu_result, 32'hF800_0000);
        step(mk(K_SLTU, 12, 14, 15, 0, 32'hFFFF_FFFF, 0, 32'h214), 1'b1, "sltu", tk, tg);
        check("sltu.result", ex_mem.alu_result, 32'd1);
        step(mk(K_BNONE, 16, 17, 0, 5, 5, 32'h40, 32'h300), 1'b1, "bnone", tk, tg);
        check("bnone.take", tk, 1'b0);

        #2;
        id_ex   = '0;
        reset_n = 1'b0;
        #1;
        check("midreset.ex_mem", ex_mem, '0);
        check("midreset.take", take_branch, 1'b0);
        check("midreset.target", branch_target, 32'd0);
        mdl_q  = '0;
        mdl_br = 1'b0;
        #3 reset_n = 1'b1;
        step(mk(K_NOP, 0, 0, 0, 0, 0, 0, 0), 1'b1, "bubble1", tk, tg);
        step(mk(K_NOP, 0, 0, 0, 0, 0, 0, 0), 1'b1, "bubble2", tk, tg);
        check("bubble.ex_mem", ex_mem, '0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            r  = $urandom;
            ri = mk(kind_e'($urandom_range(0, int'(K_LUI))), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 8)) : $urandom,
                    ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 8)) : $urandom,
                    {{20{r[11]}}, r[11:0]}, $urandom & 32'hFFFF_FFFC);
            if (ri.k inside {K_SLLI, K_SRLI, K_SRAI})
                ri.imm = ((ri.k == K_SRAI) ? 32'h400 : 32'h0) | 32'($urandom_range(0, 31));
            else if (ri.k == K_LUI)
                ri.imm = $urandom & 32'hFFFF_F000;
            else if (ri.k inside {[K_BEQ:K_BNONE], K_JAL})
                ri.imm[0] = 1'b0;
            wb_we   = 1'($urandom_range(0, 1));
            wb_addr = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            step(ri, ($urandom_range(0, 3) != 0), "rand", tk, tg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
